wb_stage: RTL and testbench

WB_STAGE -- requirements
Module: wb_stage

---
 rtl/wb_stage_pkg.sv | 47 ++++
 rtl/wb_stage_w_ext.sv | 41 ++++
 rtl/wb_stage.sv | 86 ++++++++
 tb/tb_wb_stage.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared constants and types for the write-back stage: write-data select codes,
// load extension codes, the reset PC and the MEM/WB pipeline register layout.
package wb_stage_pkg;

  localparam logic [1:0] WD_ALU  = 2'd0;
  localparam logic [1:0] WD_MEM  = 2'd1;
  localparam logic [1:0] WD_PC8  = 2'd2;
  localparam logic [1:0] WD_ZERO = 2'd3;

  localparam logic [2:0] LD_W  = 3'd0;
  localparam logic [2:0] LD_B  = 3'd1;
  localparam logic [2:0] LD_BU = 3'd2;
  localparam logic [2:0] LD_H  = 3'd3;
  localparam logic [2:0] LD_HU = 3'd4;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] alu_out;
    logic [31:0] mem_rd;
    logic [4:0]  reg_addr;
    logic        reg_we;
    logic [1:0]  wd_src;
    logic [2:0]  load_op;
  } mem_wb_t;

  localparam mem_wb_t MEM_WB_RESET = '{
    valid:    1'b0,
    pc:       PC_RESET,
    instr:    32'd0,
    alu_out:  32'd0,
    mem_rd:   32'd0,
    reg_addr: 5'd0,
    reg_we:   1'b0,
    wd_src:   WD_ALU,
    load_op:  LD_W
  };

  // Return address of a link instruction: skips the delay slot, wraps mod 2^32.
  function automatic logic [31:0] link_addr(input logic [31:0] pc);
    return pc + 32'd8;
  endfunction

endpackage

// File: rtl/wb_stage_w_ext.sv
// W_EXT: combinational load extender. Picks the byte/half lane addressed by the
// low address bits out of an aligned memory word and sign/zero extends it.
module W_EXT
  import wb_stage_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [2:0]  LoadOp,
  output logic [31:0] ext
);

  logic [7:0]  byte_lane [4];
  logic [15:0] half_lane [2];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
      assign byte_lane[gi] = word[gi*8 +: 8];
    end
    for (genvar gi = 0; gi < 2; gi++) begin : g_half
      assign half_lane[gi] = word[gi*16 +: 16];
    end
  endgenerate

  // Halfword lane ignores offset[0]; misaligned halves read the containing half.
  assign sel_byte = byte_lane[offset];
  assign sel_half = half_lane[offset[1]];

  always_comb begin
    ext = word;
    case (LoadOp)
      LD_B:    ext = {{24{sel_byte[7]}}, sel_byte};
      LD_BU:   ext = {24'd0, sel_byte};
      LD_H:    ext = {{16{sel_half[15]}}, sel_half};
      LD_HU:   ext = {16'd0, sel_half};
      default: ext = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: MEM/WB pipeline register plus write-back data selection and retire
// counter. Optional macro WB_TRACE_EN adds a simulation-only GRF write trace.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        Valid_M,
  input  logic [31:0] PC_M,
  input  logic [31:0] Instr_M,
  input  logic [31:0] ALUOut_M,
  input  logic [31:0] MemRD_M,
  input  logic [4:0]  RegAddr_M,
  input  logic        RegWE_M,
  input  logic [1:0]  WDSrc_M,
  input  logic [2:0]  LoadOp_M,
  output logic        WE,
  output logic [4:0]  WriteReg,
  output logic [31:0] WriteData,
  output logic [31:0] PC_WB,
  output logic [31:0] Instr_WB,
  output logic [31:0] FWD_WtD,
  output logic [31:0] RetireCnt
);

  mem_wb_t     mem_wb_reg;
  logic [31:0] retire_cnt_reg;
  logic [31:0] load_data;
  logic [31:0] write_data_next;

  // A bubble still loads the register so stale write enables never linger.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_wb_reg     <= MEM_WB_RESET;
      retire_cnt_reg <= 32'd0;
    end else begin
      mem_wb_reg.valid    <= Valid_M;
      mem_wb_reg.pc       <= PC_M;
      mem_wb_reg.instr    <= Instr_M;
      mem_wb_reg.alu_out  <= ALUOut_M;
      mem_wb_reg.mem_rd   <= MemRD_M;
      mem_wb_reg.reg_addr <= RegAddr_M;
      mem_wb_reg.reg_we   <= RegWE_M;
      mem_wb_reg.wd_src   <= WDSrc_M;
      mem_wb_reg.load_op  <= LoadOp_M;
      if (Valid_M) begin
        retire_cnt_reg <= retire_cnt_reg + 32'd1;
      end
    end
  end

  W_EXT u_w_ext (
    .word   (mem_wb_reg.mem_rd),
    .offset (mem_wb_reg.alu_out[1:0]),
    .LoadOp (mem_wb_reg.load_op),
    .ext    (load_data)
  );

  always_comb begin
    write_data_next = 32'd0;
    case (mem_wb_reg.wd_src)
      WD_ALU:  write_data_next = mem_wb_reg.alu_out;
      WD_MEM:  write_data_next = load_data;
      WD_PC8:  write_data_next = link_addr(mem_wb_reg.pc);
      default: write_data_next = 32'd0;
    endcase
  end

  // $0 is hardwired: the instruction retires but the GRF is left untouched.
  assign WE        = mem_wb_reg.valid & mem_wb_reg.reg_we & (mem_wb_reg.reg_addr != 5'd0);
  assign WriteReg  = mem_wb_reg.reg_addr;
  assign WriteData = write_data_next;
  assign FWD_WtD   = write_data_next;
  assign PC_WB     = mem_wb_reg.pc;
  assign Instr_WB  = mem_wb_reg.instr;
  assign RetireCnt = retire_cnt_reg;

`ifdef WB_TRACE_EN
  always_ff @(posedge clk) begin
    if (WE) begin
      $display("@%08h: $%02d <= %08h", PC_WB, WriteReg, WriteData);
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed literal cases plus randomized traffic checked
// every cycle against a behavioural model of the write-back rules.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        Valid_M;
  logic [31:0] PC_M, Instr_M, ALUOut_M, MemRD_M;
  logic [4:0]  RegAddr_M;
  logic        RegWE_M;
  logic [1:0]  WDSrc_M;
  logic [2:0]  LoadOp_M;
  logic        WE;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData, PC_WB, Instr_WB, FWD_WtD, RetireCnt;

  int checks = 0;
  int errors = 0;

  // Model expectations for the outputs currently held by the stage.
  logic        m_we;
  logic [4:0]  m_reg;
  logic [31:0] m_data, m_pc, m_instr, m_cnt;
  bit          chk_en = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk       (clk),
    .reset     (reset),
    .Valid_M   (Valid_M),
    .PC_M      (PC_M),
    .Instr_M   (Instr_M),
    .ALUOut_M  (ALUOut_M),
    .MemRD_M   (MemRD_M),
    .RegAddr_M (RegAddr_M),
    .RegWE_M   (RegWE_M),
    .WDSrc_M   (WDSrc_M),
    .LoadOp_M  (LoadOp_M),
    .WE        (WE),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .PC_WB     (PC_WB),
    .Instr_WB  (Instr_WB),
    .FWD_WtD   (FWD_WtD),
    .RetireCnt (RetireCnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [2:0] op);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (op)
      3'd1:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd2:    return b;
      3'd3:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd4:    return h;
      default: return w;
    endcase
  endfunction

  // Reference model: what the stage must show after each edge.
  always @(posedge clk) begin
    chk_en = 1;
    if (!reset) begin
      m_we = 0; m_reg = 0; m_data = 0; m_pc = 32'h0000_3000; m_instr = 0; m_cnt = 0;
    end else begin
      m_we    = Valid_M && RegWE_M && (RegAddr_M != 0);
      m_reg   = RegAddr_M;
      m_pc    = PC_M;
      m_instr = Instr_M;
      case (WDSrc_M)
        2'd0:    m_data = ALUOut_M;
        2'd1:    m_data = model_load(MemRD_M, ALUOut_M[1:0], LoadOp_M);
        2'd2:    m_data = PC_M + 32'd8;
        default: m_data = 32'd0;
      endcase
      if (Valid_M) m_cnt = m_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_WE", {31'd0, WE}, {31'd0, m_we});
      chk("cyc_WriteReg", {27'd0, WriteReg}, {27'd0, m_reg});
      chk("cyc_WriteData", WriteData, m_data);
      chk("cyc_FWD_WtD", FWD_WtD, m_data);
      chk("cyc_PC_WB", PC_WB, m_pc);
      chk("cyc_Instr_WB", Instr_WB, m_instr);
      chk("cyc_RetireCnt", RetireCnt, m_cnt);
    end
  end

  // Apply one MEM-stage slot, let one edge capture it, return at posedge+2.
  task automatic step(input logic rst, input logic v, input logic [31:0] pc,
                      input logic [31:0] alu, input logic [31:0] rd, input logic [4:0] ra,
                      input logic rwe, input logic [1:0] wds, input logic [2:0] lop);
    reset = rst; Valid_M = v; PC_M = pc; Instr_M = pc ^ 32'hA5A5_0000; ALUOut_M = alu;
    MemRD_M = rd; RegAddr_M = ra; RegWE_M = rwe; WDSrc_M = wds; LoadOp_M = lop;
    @(posedge clk);
    #2;
  endtask

  initial begin
    step(0, 1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1, 5'd9, 1, 2'd0, 3'd0);
    step(0, 1, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1, 5'd9, 1, 2'd0, 3'd0);
    chk("rst_WE", {31'd0, WE}, 32'd0);
    chk("rst_WriteData", WriteData, 32'd0);
    chk("rst_PC_WB", PC_WB, 32'h0000_3000);
    chk("rst_RetireCnt", RetireCnt, 32'd0);

    step(1, 1, 32'h3000, 32'h0, 32'h8000_00F0, 5'd8, 1, 2'd1, 3'd0);
    chk("lw_WE", {31'd0, WE}, 32'd1);
    chk("lw_WriteReg", {27'd0, WriteReg}, 32'd8);
    chk("lw_WriteData", WriteData, 32'h8000_00F0);
    chk("lw_RetireCnt", RetireCnt, 32'd1);
    step(1, 1, 32'h3004, 32'h3, 32'h8F00_0000, 5'd4, 1, 2'd1, 3'd1);
    chk("lb_data", WriteData, 32'hFFFF_FF8F);
    step(1, 1, 32'h3008, 32'h3, 32'h8F00_0000, 5'd4, 1, 2'd1, 3'd2);
    chk("lbu_data", WriteData, 32'h0000_008F);
    step(1, 1, 32'h300C, 32'h2, 32'h8001_7FFF, 5'd5, 1, 2'd1, 3'd3);
    chk("lh_data", WriteData, 32'hFFFF_8001);
    step(1, 1, 32'h3010, 32'h0, 32'h8001_7FFF, 5'd5, 1, 2'd1, 3'd4);
    chk("lhu_data", WriteData, 32'h0000_7FFF);
    step(1, 1, 32'h3014, 32'h3, 32'h8001_7FFF, 5'd5, 1, 2'd1, 3'd3);
    chk("lh_odd_data", WriteData, 32'hFFFF_8001);
    step(1, 1, 32'h3010, 32'h0, 32'h0, 5'd31, 1, 2'd2, 3'd0);
    chk("jal_data", WriteData, 32'h0000_3018);
    chk("jal_WE", {31'd0, WE}, 32'd1);
    step(1, 1, 32'h3010, 32'h0, 32'h0, 5'd0, 1, 2'd2, 3'd0);
    chk("r0_WE", {31'd0, WE}, 32'd0);
    chk("r0_RetireCnt", RetireCnt, 32'd8);
    step(1, 0, 32'h3020, 32'h77, 32'h0, 5'd5, 1, 2'd0, 3'd0);
    chk("bubble_WE", {31'd0, WE}, 32'd0);
    chk("bubble_RetireCnt", RetireCnt, 32'd8);
    step(1, 1, 32'hFFFF_FFFC, 32'h77, 32'h0, 5'd6, 1, 2'd2, 3'd0);
    chk("pc8_wrap", WriteData, 32'h0000_0004);
    step(1, 1, 32'h3028, 32'h77, 32'h0, 5'd6, 1, 2'd3, 3'd0);
    chk("zero_src", WriteData, 32'd0);
    step(0, 1, 32'h302C, 32'h55, 32'h0, 5'd7, 1, 2'd0, 3'd0);
    chk("midrst_WE", {31'd0, WE}, 32'd0);
    chk("midrst_WriteReg", {27'd0, WriteReg}, 32'd0);
    chk("midrst_PC_WB", PC_WB, 32'h0000_3000);
    chk("midrst_Instr_WB", Instr_WB, 32'd0);
    chk("midrst_RetireCnt", RetireCnt, 32'd0);

    dut.retire_cnt_reg = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step(1, 0, 32'h3030, 32'h0, 32'h0, 5'd0, 0, 2'd0, 3'd0);
    chk("preload_RetireCnt", RetireCnt, 32'hFFFF_FFFF);
    step(1, 1, 32'h3034, 32'h0, 32'h0, 5'd3, 1, 2'd0, 3'd0);
    chk("wrap_RetireCnt", RetireCnt, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), $urandom, $urandom,
           $urandom, 5'($urandom_range(0, 31)), 1'($urandom), 2'($urandom),
           3'($urandom_range(0, 7)));
    end

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
